// File: rtl/operand_fifo_taint.sv
// Operand-pair FIFO feeding a multiplier, with per-entry data taint and a
// sticky control-taint bit for the valid/ready handshake.
module operand_fifo_taint #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4  // power of two, at least 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_valid_t,
    input  logic [WIDTH-1:0]           in_a,
    input  logic                       in_a_t,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       in_b_t,
    output logic                       in_ready,
    output logic                       in_ready_t,
    output logic                       out_valid,
    output logic                       out_valid_t,
    output logic [WIDTH-1:0]           out_a,
    output logic                       out_a_t,
    output logic [WIDTH-1:0]           out_b,
    output logic                       out_b_t,
    input  logic                       out_ready,
    input  logic                       out_ready_t,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       count_t
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_a  [DEPTH];
    logic [WIDTH-1:0] mem_b  [DEPTH];
    logic             mem_at [DEPTH];
    logic             mem_bt [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          ctrl_t;
    logic          enq;
    logic          deq;

    // Handshake derives only from registered occupancy, so a full FIFO
    // never accepts even when the head leaves in the same cycle.
    always_comb begin
        in_ready  = (count != CW'(DEPTH));
        out_valid = (count != '0);
        enq       = in_valid && in_ready;
        deq       = out_valid && out_ready;
    end

    always_comb begin
        out_a       = out_valid ? mem_a[rd_ptr] : '0;
        out_b       = out_valid ? mem_b[rd_ptr] : '0;
        out_a_t     = (out_valid && mem_at[rd_ptr]) || ctrl_t;
        out_b_t     = (out_valid && mem_bt[rd_ptr]) || ctrl_t;
        in_ready_t  = ctrl_t;
        out_valid_t = ctrl_t;
        count_t     = ctrl_t;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_a[i]  <= '0;
                mem_b[i]  <= '0;
                mem_at[i] <= 1'b0;
                mem_bt[i] <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ctrl_t <= 1'b0;
        end else begin
            if (enq) begin
                mem_a[wr_ptr]  <= in_a;
                mem_b[wr_ptr]  <= in_b;
                mem_at[wr_ptr] <= in_a_t;
                mem_bt[wr_ptr] <= in_b_t;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Operand taint is deliberately excluded: only handshake taint
            // can make the control path uncertain.
            if (in_valid_t || out_ready_t) begin
                ctrl_t <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_operand_fifo_taint.sv
// Randomized bench for operand_fifo_taint against a queue-based reference model.
module tb_operand_fifo_taint;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             at;
        logic             bt;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0, in_valid_t = 1'b0;
    logic [WIDTH-1:0] in_a = '0, in_b = '0;
    logic             in_a_t = 1'b0, in_b_t = 1'b0;
    logic             in_ready, in_ready_t;
    logic             out_valid, out_valid_t;
    logic [WIDTH-1:0] out_a, out_b;
    logic             out_a_t, out_b_t;
    logic             out_ready = 1'b0, out_ready_t = 1'b0;
    logic [$clog2(DEPTH):0] count;
    logic             count_t;

    ent_t q[$];
    bit   m_ctrl;
    int   n_checks = 0;
    int   n_pass = 0;

    operand_fifo_taint #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_valid_t(in_valid_t),
        .in_a(in_a), .in_a_t(in_a_t), .in_b(in_b), .in_b_t(in_b_t),
        .in_ready(in_ready), .in_ready_t(in_ready_t),
        .out_valid(out_valid), .out_valid_t(out_valid_t),
        .out_a(out_a), .out_a_t(out_a_t), .out_b(out_b), .out_b_t(out_b_t),
        .out_ready(out_ready), .out_ready_t(out_ready_t),
        .count(count), .count_t(count_t)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic compare_all(input string tag);
        int sz = q.size();
        check({tag, ".out_valid"},   32'(out_valid),   32'(sz != 0));
        check({tag, ".in_ready"},    32'(in_ready),    32'(sz != DEPTH));
        check({tag, ".count"},       32'(count),       32'(sz));
        check({tag, ".out_a"},       32'(out_a),       sz != 0 ? 32'(q[0].a) : 32'd0);
        check({tag, ".out_b"},       32'(out_b),       sz != 0 ? 32'(q[0].b) : 32'd0);
        check({tag, ".out_a_t"},     32'(out_a_t),     32'((sz != 0 && q[0].at) || m_ctrl));
        check({tag, ".out_b_t"},     32'(out_b_t),     32'((sz != 0 && q[0].bt) || m_ctrl));
        check({tag, ".in_ready_t"},  32'(in_ready_t),  32'(m_ctrl));
        check({tag, ".out_valid_t"}, 32'(out_valid_t), 32'(m_ctrl));
        check({tag, ".count_t"},     32'(count_t),     32'(m_ctrl));
    endtask

    task automatic drive(input bit v, input bit vt, input int a, input bit at,
                         input int b, input bit bt, input bit r, input bit rt);
        in_valid = v;  in_valid_t = vt;
        in_a = WIDTH'(a); in_a_t = at;
        in_b = WIDTH'(b); in_b_t = bt;
        out_ready = r; out_ready_t = rt;
    endtask

    // Check current outputs, then advance one edge and update the model.
    task automatic step(input string tag);
        bit do_enq, do_deq;
        ent_t e;
        compare_all(tag);
        @(posedge clk);
        do_enq = in_valid && (q.size() != DEPTH);
        do_deq = out_ready && (q.size() != 0);
        if (do_deq) void'(q.pop_front());
        if (do_enq) begin
            e.a = in_a; e.b = in_b; e.at = in_a_t; e.bt = in_b_t;
            q.push_back(e);
        end
        if (in_valid_t || out_ready_t) m_ctrl = 1'b1;
        #1;
    endtask

    // Assert reset between edges, check the asynchronous effect, release.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        q.delete();
        m_ctrl = 1'b0;
        compare_all({tag, ".during"});
        @(posedge clk);
        #1 rst = 1'b0;
        #1 compare_all({tag, ".after"});
    endtask

    initial begin
        m_ctrl = 1'b0;
        #1 compare_all("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // single enqueue into empty FIFO
        drive(1, 0, 3, 0, 5, 0, 0, 0);
        step("enq1");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("enq1.a_const", 32'(out_a), 32'd3);
        check("enq1.b_const", 32'(out_b), 32'd5);
        check("enq1.cnt_const", 32'(count), 32'd1);
        step("enq1.hold");
        do_reset("r0");

        // fill, overflow offer, drain
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, i, 0, i, 0, 0, 0);
            step("fill");
        end
        check("full.ready_const", 32'(in_ready), 32'd0);
        drive(1, 0, 9, 0, 9, 0, 0, 0);
        step("overflow");
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            check("drain_const", 32'(out_a), 32'(i));
            step("drain");
        end
        check("empty.cnt_const", 32'(count), 32'd0);

        // steady state at count=2 with wrap-around
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 10 + i, 0, i, 0, 0, 0);
            step("pre2");
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, i, 0, 15 - i, 0, 1, 0);
            step("simul");
        end
        check("simul.cnt_const", 32'(count), 32'd2);
        do_reset("r1");

        // per-entry data taint, no control taint
        drive(1, 0, 7, 1, 0, 0, 0, 0);
        step("taint_a");
        drive(1, 0, 2, 0, 2, 0, 0, 0);
        step("taint_b");
        check("taint.head_a_t_const", 32'(out_a_t), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step("taint_deq");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("taint.after_deq_const", 32'(out_a_t), 32'd0);
        step("taint_idle");

        // control taint is sticky
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step("ctl_set");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("ctl.count_t_const", 32'(count_t), 32'd1);
        step("ctl_hold");
        step("ctl_hold2");

        // reset with occupancy 3
        do_reset("r2");
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, i + 4, 0, i + 8, 0, 0, 0);
            step("fill3");
        end
        check("fill3.cnt_const", 32'(count), 32'd3);
        do_reset("r3");

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 79) == 0),
                  int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 79) == 0));
            if ($urandom_range(0, 59) == 0) do_reset("rnd_rst");
            else step("rnd");
        end
        compare_all("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
